pipelined_chunk_adder: RTL and testbench

- Parametrised, multi-cycle successor to the fixed 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry.
- Supports add/subtract mode and signed-overflow detection.
- Uses a valid/ready handshake on both input and output, so it sits between datapath stages that can stall.

---
 rtl/adder_pkg.sv | 18 +
 rtl/chunk_adder.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_chunk_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state type and parameter helpers for the chunked adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple of full_adder cells
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out    = carry[CHUNK];
    // Carry into the top bit; XOR with c_out gives signed overflow on the last chunk.
    assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipelined_chunk_adder.sv
// rtl/pipelined_chunk_adder.sv - multi-cycle add/sub, CHUNK bits per clock, valid/ready on both sides
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t                        state;
    state_t                        state_next;
    logic [CW-1:0]                 cnt;
    logic [WIDTH-1:0]              op_a;
    logic [WIDTH-1:0]              op_b;
    logic                          carry;
    logic [WIDTH-1:0]              sum_r;
    logic                          c_out_r;
    logic                          ovf_r;
    logic [NCHUNK-1:0][CHUNK-1:0]  sum_next;
    logic [CHUNK-1:0]              ch_sum;
    logic                          ch_cout;
    logic                          ch_msb_in;
    logic                          accept;
    logic                          last_chunk;

    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt == CW'(NCHUNK - 1));

    // Operands shift down each BUSY cycle so the adder always sees the low chunk.
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a        (op_a[CHUNK-1:0]),
        .b        (op_b[CHUNK-1:0]),
        .c_in     (carry),
        .sum      (ch_sum),
        .c_out    (ch_cout),
        .c_msb_in (ch_msb_in)
    );

    for (genvar j = 0; j < NCHUNK; j++) begin : g_sum_slot
        assign sum_next[j] = (cnt == CW'(j)) ? ch_sum : sum_r[j*CHUNK +: CHUNK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    carry <= ch_cout;
                    sum_r <= sum_next;
                    cnt   <= cnt + CW'(1);
                    if (last_chunk) begin
                        c_out_r <= ch_cout;
                        ovf_r   <= ch_msb_in ^ ch_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb/tb_pipelined_chunk_adder.sv - self-checking bench for pipelined_chunk_adder over four parameter sets
module tb_pipelined_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic        out_ready;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  busy;
    logic [3:0]  c_out;
    logic [3:0]  ovf;
    logic [15:0] sum0;
    logic [15:0] sum1;
    logic [15:0] sum2;
    logic [31:0] sum3;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready), .sum(sum0),
        .c_out(c_out[0]), .overflow(ovf[0]), .busy(busy[0])
    );

    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready), .sum(sum1),
        .c_out(c_out[1]), .overflow(ovf[1]), .busy(busy[1])
    );

    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sum2),
        .c_out(c_out[2]), .overflow(ovf[2]), .busy(busy[2])
    );

    pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid[3]), .out_ready(out_ready), .sum(sum3),
        .c_out(c_out[3]), .overflow(ovf[3]), .busy(busy[3])
    );

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0:       return {16'h0, sum0};
            1:       return {16'h0, sum1};
            2:       return {16'h0, sum2};
            default: return sum3;
        endcase
    endfunction

    // Reference: plain wide arithmetic; overflow from operand/result sign bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv, input logic sv);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] full;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'h0, av} & mask;
        bb   = (sv ? ~{32'h0, bv} : {32'h0, bv}) & mask;
        full = aa + bb + {63'h0, (sv ? 1'b1 : cv)};
        s    = full & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input int k, input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic sv, input int lat_exp, input int hold,
                          output logic [31:0] s_o, output logic co_o, output logic ov_o);
        logic [33:0] ref_v;
        int          lat;
        ref_v = model(w, av, bv, cv, sv);
        @(negedge clk);
        chk("in_ready_before", {63'h0, in_ready[k]}, 64'd1);
        a = av; b = bv; c_in = cv; sub = sv;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        if (lat_exp > 1) chk("busy_after_accept", {63'h0, busy[k]}, 64'd1);
        while (!out_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid[k]) begin
            lat = 0;
            @(posedge clk); #1;
        end
        else begin
            lat = 0;
        end
        s_o  = get_sum(k);
        co_o = c_out[k];
        ov_o = ovf[k];
        chk("sum", {32'h0, s_o}, {32'h0, ref_v[31:0]});
        chk("c_out", {63'h0, co_o}, {63'h0, ref_v[32]});
        chk("overflow", {63'h0, ov_o}, {63'h0, ref_v[33]});
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'($urandom);
            a = $urandom; b = $urandom; sub = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", {63'h0, out_valid[k]}, 64'd1);
            chk("hold_in_ready", {63'h0, in_ready[k]}, 64'd0);
            chk("hold_sum", {32'h0, get_sum(k)}, {32'h0, s_o});
            chk("hold_flags", {62'h0, c_out[k], ovf[k]}, {62'h0, co_o, ov_o});
        end
        in_valid[k] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_out_valid", {63'h0, out_valid[k]}, 64'd0);
        chk("post_busy", {63'h0, busy[k]}, 64'd0);
        chk("post_in_ready", {63'h0, in_ready[k]}, 64'd1);
        chk("post_sum_kept", {32'h0, get_sum(k)}, {32'h0, s_o});
    endtask

    // Latency is measured separately from run_op so it counts edges from the accept edge.
    task automatic measure_lat(input int k, input logic [31:0] av, input logic [31:0] bv, input int lat_exp);
        int lat;
        @(negedge clk);
        a = av; b = bv; c_in = 1'b0; sub = 1'b0;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(lat_exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          widths [4] = '{16, 16, 16, 32};
        int          lats   [4] = '{4, 1, 16, 4};
        logic [31:0] edges  [6] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00007FFF, 32'h00008000};

        rst = 1'b1; in_valid = '0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_low", {60'h0, in_ready}, 64'h0);
        chk("rst_out_valid", {60'h0, out_valid}, 64'h0);
        chk("rst_busy", {60'h0, busy}, 64'h0);
        chk("rst_sum0", {48'h0, sum0}, 64'h0);
        chk("rst_flags", {56'h0, c_out, ovf}, 64'h0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", {60'h0, in_ready}, 64'hF);

        for (int k = 0; k < 4; k++) measure_lat(k, 32'h1234, 32'h4321, lats[k]);

        run_op(0, 16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 4, 0, s, co, ov);
        chk("t1_sum", {32'h0, s}, 64'h0000);
        chk("t1_flags", {62'h0, co, ov}, 64'b10);

        run_op(0, 16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 4, 0, s, co, ov);
        chk("t2a_sum", {32'h0, s}, 64'h8000);
        chk("t2a_flags", {62'h0, co, ov}, 64'b01);
        run_op(0, 16, 32'h1234, 32'h0FFF, 1'b1, 1'b0, 4, 0, s, co, ov);
        chk("t2b_sum", {32'h0, s}, 64'h2234);
        chk("t2b_flags", {62'h0, co, ov}, 64'b00);

        run_op(0, 16, 32'h0005, 32'h0007, 1'b1, 1'b1, 4, 0, s, co, ov);
        chk("t3a_sum", {32'h0, s}, 64'hFFFE);
        chk("t3a_flags", {62'h0, co, ov}, 64'b00);
        run_op(0, 16, 32'h8000, 32'h0001, 1'b1, 1'b1, 4, 0, s, co, ov);
        chk("t3b_sum", {32'h0, s}, 64'h7FFF);
        chk("t3b_flags", {62'h0, co, ov}, 64'b11);

        run_op(0, 16, 32'hABCD, 32'h1234, 1'b0, 1'b0, 4, 10, s, co, ov);
        chk("t4_sum", {32'h0, s}, 64'hBE01);
        run_op(0, 16, 32'h0100, 32'h0001, 1'b0, 1'b1, 4, 0, s, co, ov);
        chk("t4_next_sum", {32'h0, s}, 64'h00FF);

        @(negedge clk);
        a = 32'h1111; b = 32'h2222; c_in = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_busy_mid", {63'h0, busy[0]}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_in_ready_in_rst", {63'h0, in_ready[0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_out_valid", {63'h0, out_valid[0]}, 64'd0);
        chk("t5_busy", {63'h0, busy[0]}, 64'd0);
        chk("t5_sum", {48'h0, sum0}, 64'h0);
        chk("t5_in_ready", {63'h0, in_ready[0]}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_partial", {63'h0, out_valid[0]}, 64'd0);
        run_op(0, 16, 32'h00FF, 32'h0001, 1'b0, 1'b0, 4, 0, s, co, ov);
        chk("t5_after_sum", {32'h0, s}, 64'h0100);

        for (int k = 0; k < 4; k++) begin
            int nops;
            nops = (k == 0) ? 200 : 1000;
            for (int i = 0; i < nops; i++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
                rb = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
                run_op(k, widths[k], ra, rb, 1'($urandom), 1'($urandom), lats[k],
                       (i % 97 == 0) ? 2 : 0, s, co, ov);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
